circle_points: RTL
==================

Name: circle_points

Overview:
- Inverse companion to the point-pair distance pipeline: takes a centre and a radius, and streams every integer point of the rasterised circle of that radius.
- Uses the midpoint circle algorithm with 8-way octant symmetry.
- Sits upstream of drawing and collision logic, which consume the points through a valid/ready stream.
- Points outside the unsigned coordinate range are clipped, i.e. not emitted.

Parameters:
- W, 8: coordinate and radius width; all coordinates are unsigned 0..2^W-1.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only when busy=0.
- cx  in  W  centre x; captured on accepted start.
- cy  in  W  centre y; captured on accepted start.
- r  in  W  radius; captured on accepted start.
- busy  out  1  high from the cycle after an accepted start through the done cycle.
- px  out  W  point x.
- py  out  W  point y.
- pvalid  out  1  px/py hold a valid point.
- pready  in  1  consumer accepts the point when pvalid&&pready.
- done  out  1  one-cycle pulse when the circle is complete.

Behaviour:
- Reset (async assert, sync release): state=IDLE; busy=0, pvalid=0, done=0, px=0, py=0.
- Internal registers: x, y (W bits unsigned); err (signed, W+3 bits); oct (3 bits).
- A reset mid-operation aborts immediately. The partial point stream is simply abandoned; no done pulse.
- FSM states: IDLE, INIT, EMIT, STEP, FIN.
- IDLE:
  - start=1 captures cx, cy, r and moves to INIT.
  - start while busy=1 is ignored, and is not queued.
- INIT: x=r, y=0, err=1-r, oct=0, then go to EMIT.
  - First pvalid can therefore appear 2 cycles after the start edge.
- EMIT evaluates one octant candidate per cycle, in this fixed order for oct 0..7:
  - (cx+x, cy+y), (cx+y, cy+x), (cx-y, cy+x), (cx-x, cy+y)
  - (cx-x, cy-y), (cx-y, cy-x), (cx+y, cy-x), (cx+x, cy-y)
- Clipping: sums and differences are computed at W+1 bits signed. A candidate with any coordinate <0 or >2^W-1 is skipped. It takes 1 cycle, pvalid stays 0, and oct advances.
- An in-range candidate drives px/py with pvalid=1.
  - While pvalid&&!pready: px, py and pvalid hold stable and oct does not advance.
  - On the handshake, oct advances.
  - pvalid is registered; back-to-back points with no idle cycle are permitted when pready is held high.
- After oct=7 is handled, go to STEP.
- r=0 special case: only oct 0 is evaluated, so exactly one point (cx,cy) is emitted, then FIN.
- STEP (uses updated values):
  - y<=y+1.
  - If err<0: err<=err+2*y_new+1.
  - Else: x<=x-1 and err<=err+2*(y_new-x_new)+1.
  - If y_new<=x_new, go to EMIT with oct=0; otherwise go to FIN.
- Duplicate points at the octant boundaries (y=0 or x=y) are emitted as generated; no de-duplication.
- FIN: done=1 for one cycle, busy drops with it, then IDLE.
- done also fires when every candidate was clipped and zero points were emitted.
- The earliest new start is accepted on the cycle after FIN.

Decomposition:
- Shared package holds:
  - the state enum (IDLE/INIT/EMIT/STEP/FIN);
  - the octant ordering constants;
  - W-derived widths (ERR_W=W+3).
- One natural sub-module, circle_octant_map:
  - combinational; inputs cx, cy, x, y, oct; outputs px, py, in_range.
  - Keeps the clipping math separately unit-testable.

Test Plan:
- cx=10, cy=10, r=0, pready=1 -> exactly 1 point (10,10), then done; busy deasserts with done.
- cx=10, cy=10, r=1, pready=1 -> exactly 8 points, in this order: (11,10), (10,11), (10,11), (9,10), (9,10), (10,9), (10,9), (11,10); then done.
- cx=100, cy=100, r=3 -> 24 points from (x,y) = (3,0), (3,1), (2,2); every point satisfies |dx|^2+|dy|^2 within [r^2-r, r^2+r].
- cx=0, cy=0, r=1 -> only (1,0), (0,1), (0,1), (1,0) emitted (4 points); done still pulses.
- cx=128, cy=128, r=5 with pready toggled randomly -> px/py stable whenever pvalid&&!pready; the point sequence is identical to the pready=1 run.
- start while busy -> ignored. rst_n low during EMIT -> pvalid, busy and done clear immediately. A fresh start after release produces a complete, correct circle.

Source files
------------

// File: rtl/circle_points_pkg.sv
// Shared types and constants for the midpoint circle point generator.
package circle_points_pkg;

  // Controller states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_EMIT,
    ST_STEP,
    ST_FIN
  } state_t;

  // Octant walk runs from OCT_FIRST to OCT_LAST.
  localparam logic [2:0] OCT_FIRST = 3'd0;
  localparam logic [2:0] OCT_LAST  = 3'd7;

  // Per-octant transform tables, bit i describes octant i:
  //   swap : offsets are (y, x) instead of (x, y)
  //   neg_x: x offset is subtracted from cx
  //   neg_y: y offset is subtracted from cy
  // Order: (+x,+y) (+y,+x) (-y,+x) (-x,+y) (-x,-y) (-y,-x) (+y,-x) (+x,-y)
  localparam logic [7:0] OCT_SWAP  = 8'b0110_0110;
  localparam logic [7:0] OCT_NEG_X = 8'b0011_1100;
  localparam logic [7:0] OCT_NEG_Y = 8'b1111_0000;

  // Decision variable width: headroom for 2*(y-x)+1 accumulation plus sign.
  function automatic int err_width(input int w);
    return w + 3;
  endfunction

endpackage

// File: rtl/circle_octant_map.sv
// Maps one (x, y) offset pair and an octant index onto a clipped point
// around the centre. Purely combinational.
module circle_octant_map
  import circle_points_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] cx,
  input  logic [W-1:0] cy,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [2:0]   oct,
  output logic [W-1:0] px,
  output logic [W-1:0] py,
  output logic         in_range
);

  logic [W-1:0]        dx_mag;
  logic [W-1:0]        dy_mag;
  // One bit for the carry out of cx+x and one for the sign of cx-x.
  logic signed [W+1:0] sx;
  logic signed [W+1:0] sy;

  // Apply the octant's swap/sign pattern, then flag under- and overflow.
  always_comb begin
    dx_mag = OCT_SWAP[oct] ? y : x;
    dy_mag = OCT_SWAP[oct] ? x : y;
    if (OCT_NEG_X[oct]) sx = $signed({2'b00, cx}) - $signed({2'b00, dx_mag});
    else                sx = $signed({2'b00, cx}) + $signed({2'b00, dx_mag});
    if (OCT_NEG_Y[oct]) sy = $signed({2'b00, cy}) - $signed({2'b00, dy_mag});
    else                sy = $signed({2'b00, cy}) + $signed({2'b00, dy_mag});
    // Both top bits clear means 0 <= value <= 2^W-1.
    in_range = (sx[W+1:W] == 2'b00) && (sy[W+1:W] == 2'b00);
    px       = sx[W-1:0];
    py       = sy[W-1:0];
  end

endmodule

// File: rtl/circle_points.sv
// Midpoint circle rasteriser: streams every in-range point of a circle
// through a valid/ready interface, one octant candidate per cycle.
module circle_points
  import circle_points_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] cx,
  input  logic [W-1:0] cy,
  input  logic [W-1:0] r,
  output logic         busy,
  output logic [W-1:0] px,
  output logic [W-1:0] py,
  output logic         pvalid,
  input  logic         pready,
  output logic         done
);

  localparam int ERR_W = err_width(W);
  localparam logic signed [ERR_W-1:0] ERR_ONE = ERR_W'(1);

  state_t                    state_reg, state_next;
  logic [W-1:0]              cx_reg, cx_next;
  logic [W-1:0]              cy_reg, cy_next;
  logic [W-1:0]              r_reg, r_next;
  logic [W-1:0]              x_reg, x_next;
  logic [W-1:0]              y_reg, y_next;
  logic signed [ERR_W-1:0]   err_reg, err_next;
  logic [2:0]                oct_reg, oct_next;
  logic [W-1:0]              px_reg, px_next;
  logic [W-1:0]              py_reg, py_next;
  logic                      pvalid_reg, pvalid_next;

  logic [W-1:0]              map_px, map_py;
  logic                      map_in_range;

  logic [W-1:0]              y_inc, x_dec, x_new;
  logic signed [ERR_W-1:0]   y_s, x_s;
  logic                      stalled;

  circle_octant_map #(.W(W)) u_map (
    .cx       (cx_reg),
    .cy       (cy_reg),
    .x        (x_reg),
    .y        (y_reg),
    .oct      (oct_reg),
    .px       (map_px),
    .py       (map_py),
    .in_range (map_in_range)
  );

  assign busy   = (state_reg != ST_IDLE);
  assign px     = px_reg;
  assign py     = py_reg;
  assign pvalid = pvalid_reg;
  // done waits until the last presented point has been taken.
  assign done   = (state_reg == ST_FIN) && !pvalid_reg;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      cx_reg     <= '0;
      cy_reg     <= '0;
      r_reg      <= '0;
      x_reg      <= '0;
      y_reg      <= '0;
      err_reg    <= '0;
      oct_reg    <= OCT_FIRST;
      px_reg     <= '0;
      py_reg     <= '0;
      pvalid_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cx_reg     <= cx_next;
      cy_reg     <= cy_next;
      r_reg      <= r_next;
      x_reg      <= x_next;
      y_reg      <= y_next;
      err_reg    <= err_next;
      oct_reg    <= oct_next;
      px_reg     <= px_next;
      py_reg     <= py_next;
      pvalid_reg <= pvalid_next;
    end
  end

  // Next-state logic: capture, octant walk with backpressure, midpoint step.
  always_comb begin
    state_next  = state_reg;
    cx_next     = cx_reg;
    cy_next     = cy_reg;
    r_next      = r_reg;
    x_next      = x_reg;
    y_next      = y_reg;
    err_next    = err_reg;
    oct_next    = oct_reg;
    px_next     = px_reg;
    py_next     = py_reg;
    pvalid_next = pvalid_reg;

    stalled = pvalid_reg && !pready;
    y_inc   = y_reg + W'(1);
    x_dec   = x_reg - W'(1);
    x_new   = err_reg[ERR_W-1] ? x_reg : x_dec;
    y_s     = ERR_W'(y_inc);
    x_s     = ERR_W'(x_new);

    // A handshake in any state retires the presented point.
    if (pvalid_reg && pready) pvalid_next = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          cx_next    = cx;
          cy_next    = cy;
          r_next     = r;
          state_next = ST_INIT;
        end
      end
      ST_INIT: begin
        x_next     = r_reg;
        y_next     = '0;
        err_next   = ERR_ONE - ERR_W'(r_reg);
        oct_next   = OCT_FIRST;
        state_next = ST_EMIT;
      end
      ST_EMIT: begin
        // Evaluate a new candidate whenever the output slot is free or
        // being emptied this cycle; clipped candidates leave it empty.
        if (!stalled) begin
          pvalid_next = map_in_range;
          if (map_in_range) begin
            px_next = map_px;
            py_next = map_py;
          end
          oct_next = oct_reg + 3'd1;
          // x is only zero here for r=0, where the single centre point
          // is the whole circle.
          if (x_reg == '0)            state_next = ST_FIN;
          else if (oct_reg == OCT_LAST) state_next = ST_STEP;
        end
      end
      ST_STEP: begin
        y_next = y_inc;
        x_next = x_new;
        if (err_reg[ERR_W-1]) err_next = err_reg + (y_s <<< 1) + ERR_ONE;
        else                  err_next = err_reg + ((y_s - x_s) <<< 1) + ERR_ONE;
        if (y_inc <= x_new) begin
          oct_next   = OCT_FIRST;
          state_next = ST_EMIT;
        end else begin
          state_next = ST_FIN;
        end
      end
      ST_FIN: begin
        if (!pvalid_reg) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule
